gate_sweep_checker: RTL and testbench
=====================================

GATE_SWEEP_CHECKER -- requirements
Module: gate_sweep_checker

Interface
REQ-001 Parameter SETTLE, default 1: cycles each input vector is held before its outputs are checked; legal range 1..15.
REQ-002 Parameter PASSES, default 1: number of full 4-vector sweeps per run; legal range 1..255.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset; synchronous and active-low.
REQ-005 start  input  1  one-cycle run request; honoured only in IDLE.
REQ-006 a  output  1  gate-under-test input a; driven from vector bit 1.
REQ-007 b  output  1  gate-under-test input b; driven from vector bit 0.
REQ-008 nand_in  input  1  NAND result returned by the gate-under-test.
REQ-009 nor_in  input  1  NOR result returned by the gate-under-test.
REQ-010 busy  output  1  high while a run is in progress (APPLY or CHECK).
REQ-011 done  output  1  one-cycle pulse when a run ends.
REQ-012 pass  output  1  run verdict: 1 when err_count==0; valid from done and held until the next start.
REQ-013 err_count  output  8  number of failing checks, saturating at 255.
REQ-014 fail_vec  output  4  bit i set when vector i ({a,b}=i) failed at least once in the run.

Function
REQ-015 The FSM SHALL have four states:
- IDLE -> APPLY on start.
- APPLY -> CHECK after SETTLE cycles.
- CHECK -> APPLY (next vector) or DONE (after the last vector of the last pass).
- DONE -> IDLE unconditionally after one cycle.
REQ-016 On the accepting start edge, the block SHALL:
- clear err_count, fail_vec and pass;
- set the vector index to 0 and the pass counter to 0.
REQ-017 Vector order SHALL be {a,b} = 00, 01, 10, 11 within each pass; the index wraps from 3 to 0 and the pass counter then increments.
REQ-018 a and b SHALL hold the current vector throughout APPLY and CHECK, and SHALL be 0 in IDLE and DONE.
REQ-019 Each vector SHALL occupy exactly SETTLE+1 cycles: SETTLE cycles in APPLY, then 1 cycle in CHECK.
REQ-020 In CHECK, the expected values SHALL be nand_in = ~(a&b) and nor_in = ~(a|b), compared against the inputs sampled in that cycle.
REQ-021 A mismatch on either output SHALL:
- increment err_count by exactly 1 (a double mismatch still counts as 1);
- set fail_vec[vector].
REQ-022 err_count SHALL saturate at 255 and never wrap.
REQ-023 Run latency: busy SHALL be high for exactly PASSES*4*(SETTLE+1) cycles, starting the cycle after start is accepted, and done SHALL be high in the following cycle.
REQ-024 In DONE: busy=0, done=1, and pass = (err_count==0) including the final check's result.
REQ-025 start asserted in APPLY, CHECK or DONE SHALL be ignored (no restart, no queuing).
REQ-026 err_count, fail_vec and pass SHALL hold their values in IDLE until the next accepted start.
REQ-027 Unknown values on nand_in or nor_in outside CHECK SHALL have no effect.

Reset
REQ-028 While rst_n=0 at a clock edge, the block SHALL set:
- state = IDLE;
- a = b = busy = done = pass = 0;
- err_count = 0, fail_vec = 0, and all internal counters = 0.
REQ-029 Reset asserted mid-run SHALL abort the run with no done pulse, and the block SHALL accept start on the first edge after rst_n returns high.

Structure
REQ-030 A shared package gate_sweep_pkg SHALL hold:
- the state enumeration;
- NAND_TT = 4'b0111 and NOR_TT = 4'b0001 (truth tables indexed by {a,b});
- ERR_MAX = 8'd255.
REQ-031 Expected values SHALL be taken from NAND_TT/NOR_TT, not from inline logic.
REQ-032 The settle countdown SHALL be a separate sub-module, settle_timer: load on entry to APPLY, terminal-count output.

Verification
REQ-033 Correct DUT, SETTLE=1, PASSES=1, start at cycle 0:
- busy high cycles 1..8; a,b = 00,00,01,01,10,10,11,11;
- done at cycle 9; pass=1, err_count=0, fail_vec=0000.
REQ-034 nand_in stuck at 1, PASSES=1 -> only vector 11 fails: err_count=1, fail_vec=1000, pass=0.
REQ-035 nand_in and nor_in both inverted, PASSES=2:
- each vector counts once per pass -> err_count=8, fail_vec=1111.
REQ-036 Inverted outputs, PASSES=100:
- err_count saturates at 255 (not 144 after wrap); fail_vec=1111.
REQ-037 start pulsed again at busy cycle 3 -> ignored; done still at cycle 9 of the original run.
REQ-038 rst_n low at busy cycle 5:
- all outputs 0 next cycle, no done pulse;
- a fresh start afterwards completes normally with pass=1.

Source files
------------

// File: rtl/gate_sweep_pkg.sv
// Shared types and constants for the gate sweep checker: FSM states,
// reference truth tables indexed by {a,b}, and the error-count ceiling.
package gate_sweep_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_APPLY = 2'd1,
      S_CHECK = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   // Truth tables, bit index = {a,b}
   localparam logic [3:0] NAND_TT = 4'b0111;
   localparam logic [3:0] NOR_TT  = 4'b0001;

   localparam logic [7:0] ERR_MAX = 8'd255;

endpackage

// File: rtl/settle_timer.sv
// Settle countdown: loaded when the checker enters APPLY, tc goes high
// once SETTLE cycles of APPLY have elapsed (on the last APPLY cycle).
module settle_timer #(
   parameter int SETTLE = 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load,
   output logic tc
);

   logic [3:0] cnt_q;

   // Load SETTLE-1 on entry to APPLY, then count down to zero and hold
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= 4'd0;
      end else if (load) begin
         cnt_q <= 4'(SETTLE - 1);
      end else if (cnt_q != 4'd0) begin
         cnt_q <= cnt_q - 4'd1;
      end
   end

   assign tc = (cnt_q == 4'd0);

endmodule

// File: rtl/gate_sweep_checker.sv
// Gate sweep checker: drives the four {a,b} vectors into a NAND/NOR pair
// PASSES times, checks the returned values once per vector, and reports
// an error count, a per-vector failure map and a pass/fail verdict.
//
// Handshake: start is a single-cycle request accepted only while idle
// (busy=0, done=0); there is no backpressure and requests made while a
// run is in flight or in its done cycle are dropped, not queued.
module gate_sweep_checker
   import gate_sweep_pkg::*;
#(
   parameter int SETTLE = 1,
   parameter int PASSES = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   output logic       a,
   output logic       b,
   input  logic       nand_in,
   input  logic       nor_in,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [7:0] err_count,
   output logic [3:0] fail_vec
);

   state_t     state_q, state_d;
   logic [1:0] vec_q;
   logic [7:0] pass_cnt_q;
   logic       load;
   logic       tc;
   logic       last_vec;
   logic       mismatch;
   logic [7:0] err_next;

   settle_timer #(.SETTLE(SETTLE)) u_settle (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (load),
      .tc    (tc)
   );

   assign last_vec = (vec_q == 2'd3) && (pass_cnt_q == 8'(PASSES - 1));
   assign mismatch = (nand_in != NAND_TT[vec_q]) || (nor_in != NOR_TT[vec_q]);
   assign err_next = (mismatch && (err_count != ERR_MAX)) ? err_count + 8'd1 : err_count;

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state and timer load; load fires on every transition into APPLY
   always_comb begin
      state_d = state_q;
      load    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_APPLY;
               load    = 1'b1;
            end
         end
         S_APPLY: begin
            if (tc) state_d = S_CHECK;
         end
         S_CHECK: begin
            if (last_vec) begin
               state_d = S_DONE;
            end else begin
               state_d = S_APPLY;
               load    = 1'b1;
            end
         end
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Run bookkeeping: clear on accepted start, score and advance in CHECK
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vec_q      <= 2'd0;
         pass_cnt_q <= 8'd0;
         err_count  <= 8'd0;
         fail_vec   <= 4'd0;
         pass       <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  vec_q      <= 2'd0;
                  pass_cnt_q <= 8'd0;
                  err_count  <= 8'd0;
                  fail_vec   <= 4'd0;
                  pass       <= 1'b0;
               end
            end
            S_CHECK: begin
               err_count <= err_next;
               if (mismatch) fail_vec[vec_q] <= 1'b1;
               vec_q <= vec_q + 2'd1;
               if (vec_q == 2'd3) pass_cnt_q <= pass_cnt_q + 8'd1;
               if (last_vec) pass <= (err_next == 8'd0);
            end
            default: ;
         endcase
      end
   end

   // Outputs decoded from state; vector only driven while a run is active
   always_comb begin
      busy = (state_q == S_APPLY) || (state_q == S_CHECK);
      done = (state_q == S_DONE);
      a    = busy ? vec_q[1] : 1'b0;
      b    = busy ? vec_q[0] : 1'b0;
   end

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Bench for gate_sweep_checker: three instances with different SETTLE and
// PASSES, an emulated gate pair per instance with injectable faults, and a
// reference model derived from the sweep schedule arithmetic.
module tb_gate_sweep_checker;

  localparam int NI = 3;

  logic clk;
  logic rst_n;
  logic [NI-1:0] start_s;
  logic [NI-1:0] a_s, b_s, busy_s, done_s, pass_s;
  logic [NI-1:0] nand_s, nor_s;
  logic [7:0] err_s [NI];
  logic [3:0] fv_s [NI];

  int total;
  int bad;

  gate_sweep_checker #(.SETTLE(1), .PASSES(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start_s[0]), .a(a_s[0]), .b(b_s[0]),
    .nand_in(nand_s[0]), .nor_in(nor_s[0]), .busy(busy_s[0]), .done(done_s[0]),
    .pass(pass_s[0]), .err_count(err_s[0]), .fail_vec(fv_s[0]));

  gate_sweep_checker #(.SETTLE(3), .PASSES(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start_s[1]), .a(a_s[1]), .b(b_s[1]),
    .nand_in(nand_s[1]), .nor_in(nor_s[1]), .busy(busy_s[1]), .done(done_s[1]),
    .pass(pass_s[1]), .err_count(err_s[1]), .fail_vec(fv_s[1]));

  gate_sweep_checker #(.SETTLE(1), .PASSES(100)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start_s[2]), .a(a_s[2]), .b(b_s[2]),
    .nand_in(nand_s[2]), .nor_in(nor_s[2]), .busy(busy_s[2]), .done(done_s[2]),
    .pass(pass_s[2]), .err_count(err_s[2]), .fail_vec(fv_s[2]));

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int settle_of(input int inst);
    case (inst)
      1: return 3;
      default: return 1;
    endcase
  endfunction

  function automatic int passes_of(input int inst);
    case (inst)
      1: return 2;
      2: return 100;
      default: return 1;
    endcase
  endfunction

  // mode: 0 good gate, 1 nand stuck at 1, 2 both outputs inverted,
  // 3 random flips on check cycles with X driven everywhere else.
  // restart_at: cycle at which start is re-pulsed (0 = never).
  // rst_at: cycle at which reset is asserted mid-run (0 = never).
  task automatic run_case(input int inst, input int mode, input int restart_at,
                          input int rst_at, input string name);
    int s, p, n, v;
    bit va, vb, chk, mis, eb, ed;
    logic dn, dr;
    int exp_err;
    logic [3:0] exp_fv;
    logic [3:0] got4, want4;
    s = settle_of(inst);
    p = passes_of(inst);
    n = p * 4 * (s + 1);
    exp_err = 0;
    exp_fv = 4'd0;
    @(negedge clk);
    start_s[inst] = 1'b1;
    for (int t = 1; t <= n + 2; t++) begin
      @(negedge clk);
      start_s[inst] = (t == restart_at);
      eb = (t <= n);
      ed = (t == n + 1);
      v  = eb ? ((t - 1) / (s + 1)) % 4 : 0;
      va = v[1];
      vb = v[0];
      got4  = {busy_s[inst], done_s[inst], a_s[inst], b_s[inst]};
      want4 = {eb, ed, va, vb};
      total++;
      if (got4 !== want4) begin
        bad++;
        $display("FAIL %s cyc%0d busy/done/a/b: got %b want %b", name, t, got4, want4);
      end
      if (t == 1) begin
        total++;
        if (err_s[inst] !== 8'd0 || fv_s[inst] !== 4'd0 || pass_s[inst] !== 1'b0) begin
          bad++;
          $display("FAIL %s start_clear: got err=%0d fv=%b pass=%b want 0/0000/0",
                   name, err_s[inst], fv_s[inst], pass_s[inst]);
        end
      end
      if (t == n + 1 || t == n + 2) begin
        total++;
        if (err_s[inst] !== 8'(exp_err) || fv_s[inst] !== exp_fv ||
            pass_s[inst] !== (exp_err == 0)) begin
          bad++;
          $display("FAIL %s verdict cyc%0d: got err=%0d fv=%b pass=%b want err=%0d fv=%b pass=%b",
                   name, t, err_s[inst], fv_s[inst], pass_s[inst], exp_err, exp_fv, exp_err == 0);
        end
      end
      if (rst_at != 0 && t == rst_at) begin
        rst_n = 1'b0;
        @(negedge clk);
        total++;
        if ({busy_s[inst], done_s[inst], a_s[inst], b_s[inst], pass_s[inst]} !== 5'd0 ||
            err_s[inst] !== 8'd0 || fv_s[inst] !== 4'd0) begin
          bad++;
          $display("FAIL %s reset_clear: got busy=%b done=%b a=%b b=%b pass=%b err=%0d fv=%b want all 0",
                   name, busy_s[inst], done_s[inst], a_s[inst], b_s[inst], pass_s[inst],
                   err_s[inst], fv_s[inst]);
        end
        rst_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
          @(negedge clk);
          total++;
          if (busy_s[inst] !== 1'b0 || done_s[inst] !== 1'b0) begin
            bad++;
            $display("FAIL %s post_reset_quiet k=%0d: got busy=%b done=%b want 0 0",
                     name, k, busy_s[inst], done_s[inst]);
          end
        end
        return;
      end
      // emulated gate for the cycle now in progress
      chk = eb && ((t % (s + 1)) == 0);
      dn = !(va && vb);
      dr = !(va || vb);
      case (mode)
        1: dn = 1'b1;
        2: begin dn = !dn; dr = !dr; end
        3: begin
          if (chk) begin
            if ($urandom_range(0, 15) == 0) dn = !dn;
            if ($urandom_range(0, 15) == 0) dr = !dr;
          end else begin
            dn = 1'bx;
            dr = 1'bx;
          end
        end
        default: ;
      endcase
      nand_s[inst] = dn;
      nor_s[inst]  = dr;
      if (chk) begin
        mis = (dn !== !(va && vb)) || (dr !== !(va || vb));
        if (mis) begin
          if (exp_err < 255) exp_err++;
          exp_fv[v] = 1'b1;
        end
      end
    end
    start_s[inst] = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start_s = '0;
    nand_s = '0;
    nor_s = '0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      total++;
      if ({busy_s[i], done_s[i], a_s[i], b_s[i], pass_s[i]} !== 5'd0 ||
          err_s[i] !== 8'd0 || fv_s[i] !== 4'd0) begin
        bad++;
        $display("FAIL reset inst%0d: got busy=%b done=%b a=%b b=%b pass=%b err=%0d fv=%b want all 0",
                 i, busy_s[i], done_s[i], a_s[i], b_s[i], pass_s[i], err_s[i], fv_s[i]);
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_sweep_ok();
    run_case(0, 0, 0, 0, "ok_s1p1");
    run_case(1, 0, 0, 0, "ok_s3p2");
    run_case(2, 0, 0, 0, "ok_s1p100");
  endtask

  task automatic test_stuck_nand();
    run_case(0, 1, 0, 0, "nand_stuck1");
    run_case(1, 1, 0, 0, "nand_stuck1_p2");
  endtask

  task automatic test_inverted();
    run_case(1, 2, 0, 0, "inverted_p2");
    run_case(0, 2, 0, 0, "inverted_p1");
  endtask

  task automatic test_saturation();
    run_case(2, 2, 0, 0, "saturate_p100");
  endtask

  task automatic test_random();
    for (int r = 0; r < 6; r++) run_case(0, 3, 0, 0, "random_p1");
    run_case(1, 3, 0, 0, "random_p2");
    run_case(2, 3, 0, 0, "random_p100");
  endtask

  task automatic test_restart_ignored();
    run_case(0, 0, 3, 0, "restart_busy3");
    run_case(1, 2, 5, 0, "restart_check");
  endtask

  task automatic test_back_to_back();
    run_case(0, 1, 9, 0, "start_in_done");
    run_case(0, 0, 0, 0, "b2b_second");
  endtask

  task automatic test_midrun_reset();
    run_case(0, 2, 0, 5, "reset_busy5");
    run_case(0, 0, 0, 0, "after_reset");
  endtask

  initial begin
    total = 0;
    bad = 0;
    test_reset();
    test_sweep_ok();
    test_stuck_nand();
    test_inverted();
    test_saturation();
    test_random();
    test_restart_ignored();
    test_back_to_back();
    test_midrun_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
